camera_exposure_sweep_sequencer: RTL and testbench



---
 rtl/camera_pkg.sv | 27 ++
 rtl/camera_exposure_sweep_sequencer_frame_delta_counter.sv | 29 ++
 rtl/camera_exposure_sweep_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_camera_exposure_sweep_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/camera_pkg.sv
// Shared types and constants for the camera exposure sweep sequencer.
// Imported by the sequencer top and its frame counter helper.
package camera_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CFG_REQ,
    CFG_WAIT_LO,
    CFG_WAIT_HI,
    CAP_START,
    CAP_RUN,
    CAP_STOP,
    NEXT,
    DONE,
    ERR
  } seq_state_t;

  localparam logic [15:0] EXP_DEFAULT = 16'h0100;
  localparam int          PULSE_GAP   = 2;

  function automatic logic [15:0] at_least_one(
    input logic [15:0] v
  );
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

endpackage

// File: rtl/camera_exposure_sweep_sequencer_frame_delta_counter.sv
// Frames elapsed since capture start, modulo the counter width.
// Wrap of the free-running count is absorbed by the subtraction.
module frame_delta_counter #(
  parameter int FRAME_W = 32
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               latch,
  input  logic [FRAME_W-1:0] count,
  input  logic [FRAME_W-1:0] target,
  output logic               reached
);

  logic [FRAME_W-1:0] base_q;
  logic [FRAME_W-1:0] delta;

  // capture the frame count seen when capture starts
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      base_q <= '0;
    end else if (latch) begin
      base_q <= count;
    end
  end

  assign delta   = count - base_q;
  assign reached = (delta >= target);

endmodule

// File: rtl/camera_exposure_sweep_sequencer.sv
// Steps the camera config/capture slave through an exposure sweep.
// Reconfigure, capture N frames, stop, advance until the end value.
module camera_exposure_sweep_sequencer
  import camera_pkg::*;
#(
  parameter logic [23:0] CFG_TIMEOUT = 24'd5_000_000,
  parameter int          FRAME_W     = 32
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               go,
  input  logic               abort,
  input  logic [15:0]        exp_start,
  input  logic [15:0]        exp_end,
  input  logic [15:0]        exp_step,
  input  logic [15:0]        frames_per_exp,
  output logic               Config_start,
  input  logic               Config_done,
  output logic [15:0]        Config_Exposure,
  output logic               Capture_start,
  output logic               Capture_stop,
  input  logic [FRAME_W-1:0] Capture_Framecount,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [15:0]        cur_index
);

  seq_state_t  state_q, state_d;
  logic [15:0] exp_q, exp_d;
  logic [15:0] end_q, end_d;
  logic [15:0] step_q, step_d;
  logic [15:0] frm_q, frm_d;
  logic [15:0] idx_q, idx_d;
  logic [23:0] tmo_q, tmo_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        abt_q, abt_d;
  logic [16:0] nxt;
  logic        idle_like;
  logic        reached;

  assign idle_like = (state_q == IDLE) ||
                     (state_q == DONE) ||
                     (state_q == ERR);
  assign nxt = {1'b0, exp_q} + {1'b0, step_q};

  frame_delta_counter #(
    .FRAME_W (FRAME_W)
  ) u_delta (
    .Clock   (Clock),
    .Reset   (Reset),
    .latch   (state_q == CAP_START),
    .count   (Capture_Framecount),
    .target  (FRAME_W'(frm_q)),
    .reached (reached)
  );

  // register the sequencer state and its working values
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      exp_q   <= EXP_DEFAULT;
      end_q   <= '0;
      step_q  <= 16'd1;
      frm_q   <= 16'd1;
      idx_q   <= '0;
      tmo_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      abt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      end_q   <= end_d;
      step_q  <= step_d;
      frm_q   <= frm_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      done_q  <= done_d;
      err_q   <= err_d;
      abt_q   <= abt_d;
    end
  end

  // next state; abort overrides every other busy transition
  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    end_d   = end_q;
    step_d  = step_q;
    frm_d   = frm_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    done_d  = done_q;
    err_d   = err_q;
    abt_d   = abt_q;
    if (abort && !idle_like) begin
      state_d = IDLE;
      abt_d   = 1'b0;
      if (state_q == CAP_START || state_q == CAP_RUN) begin
        state_d = CAP_STOP;
        abt_d   = 1'b1;
      end else if (state_q == CAP_STOP) begin
        idx_d = idx_q + 16'd1;
      end
    end else begin
      unique case (state_q)
        IDLE, DONE, ERR: begin
          if (go && !abort) begin
            exp_d  = exp_start;
            end_d  = exp_end;
            step_d = at_least_one(exp_step);
            frm_d  = at_least_one(frames_per_exp);
            idx_d  = '0;
            err_d  = 1'b0;
            abt_d  = 1'b0;
            done_d = 1'b0;
            if (exp_start > exp_end) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = CFG_REQ;
            end
          end
        end
        CFG_REQ: begin
          tmo_d   = CFG_TIMEOUT - 24'd1;
          state_d = CFG_WAIT_LO;
        end
        CFG_WAIT_LO, CFG_WAIT_HI: begin
          tmo_d = (tmo_q != '0) ? tmo_q - 24'd1 : '0;
          if (state_q == CFG_WAIT_LO && !Config_done) begin
            state_d = CFG_WAIT_HI;
          end else if (state_q == CFG_WAIT_HI && Config_done) begin
            state_d = CAP_START;
          end else if (tmo_q == '0) begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
        CAP_START: begin
          state_d = CAP_RUN;
        end
        CAP_RUN: begin
          if (reached) begin
            state_d = CAP_STOP;
          end
        end
        CAP_STOP: begin
          idx_d   = idx_q + 16'd1;
          abt_d   = 1'b0;
          state_d = abt_q ? IDLE : NEXT;
        end
        NEXT: begin
          if (nxt[16] || nxt[15:0] > end_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            exp_d   = nxt[15:0];
            state_d = CFG_REQ;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign busy            = !idle_like;
  assign Config_start    = (state_q == CFG_REQ);
  assign Capture_start   = (state_q == CAP_START);
  assign Capture_stop    = (state_q == CAP_STOP);
  assign Config_Exposure = exp_q;
  assign done            = done_q;
  assign error           = err_q;
  assign cur_index       = idx_q;

endmodule

// File: tb/tb_camera_exposure_sweep_sequencer.sv
// Scoreboard bench for the exposure sweep sequencer.
// Pulses are tokenised and compared in order against a queue.
module tb_camera_exposure_sweep_sequencer;

  logic        Clock;
  logic        Reset;
  logic        go;
  logic        abort;
  logic [15:0] exp_start;
  logic [15:0] exp_end;
  logic [15:0] exp_step;
  logic [15:0] frames_per_exp;
  logic        Config_start;
  logic        Config_done;
  logic [15:0] Config_Exposure;
  logic        Capture_start;
  logic        Capture_stop;
  logic [31:0] Capture_Framecount;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] cur_index;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] sb[$];

  int          cyc = 0;
  int          cfg_seen = 0;
  int          sweep_id = 0;
  int          stop_sweep = -1;
  int          stop_cyc = 0;
  logic        mask_delta = 1'b0;
  logic        stuck = 1'b0;
  int          fc_load_n = 0;
  logic [31:0] fc_load_val = 32'd0;
  logic [31:0] base_seen = 32'd0;
  logic [31:0] last_stop_fc = 32'd0;

  camera_exposure_sweep_sequencer #(
    .CFG_TIMEOUT (24'd100),
    .FRAME_W     (32)
  ) dut (
    .Clock              (Clock),
    .Reset              (Reset),
    .go                 (go),
    .abort              (abort),
    .exp_start          (exp_start),
    .exp_end            (exp_end),
    .exp_step           (exp_step),
    .frames_per_exp     (frames_per_exp),
    .Config_start       (Config_start),
    .Config_done        (Config_done),
    .Config_Exposure    (Config_Exposure),
    .Capture_start      (Capture_start),
    .Capture_stop       (Capture_stop),
    .Capture_Framecount (Capture_Framecount),
    .busy               (busy),
    .done               (done),
    .error              (error),
    .cur_index          (cur_index)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // config engine and frame counter model
  initial begin
    int used = 0;
    int cnt = 0;
    int div = 0;
    int loads = 0;
    Config_done = 1'b1;
    Capture_Framecount = 32'd0;
    forever begin
      @(posedge Clock);
      #2;
      if (loads != fc_load_n) begin
        loads = fc_load_n;
        Capture_Framecount = fc_load_val;
        div = 0;
      end else begin
        div++;
        if (div == 50) begin
          div = 0;
          Capture_Framecount = Capture_Framecount + 32'd1;
        end
      end
      if (used != cfg_seen) begin
        used = cfg_seen;
        Config_done = 1'b0;
        cnt = stuck ? 0 : 10;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) Config_done = 1'b1;
      end else if (!stuck) begin
        Config_done = 1'b1;
      end
    end
  end

  // pulse monitor feeding the scoreboard
  always @(negedge Clock) begin
    logic [7:0]  kind;
    logic [15:0] val;
    logic [31:0] obs;
    cyc++;
    kind = {5'd0, Capture_stop, Capture_start, Config_start};
    if (kind != 8'd0) begin
      val = 16'd0;
      if (Config_start) begin
        val = Config_Exposure;
        cfg_seen++;
        if (stop_sweep == sweep_id)
          check("gap", 32'(cyc - stop_cyc >= 2), 32'd1);
      end
      if (Capture_start) base_seen = Capture_Framecount;
      if (Capture_stop) begin
        if (!mask_delta) val = 16'(Capture_Framecount - base_seen);
        last_stop_fc = Capture_Framecount;
        stop_cyc = cyc;
        stop_sweep = sweep_id;
      end
      obs = {kind, 8'd0, val};
      if (sb.size() == 0) check("unexpected", obs, 32'd0);
      else check("pulse", obs, sb.pop_front());
    end
  end

  task automatic push_sweep(
    input  logic [15:0] s,
    input  logic [15:0] e,
    input  logic [15:0] st,
    input  logic [15:0] fr,
    output int          n
  );
    logic [16:0] x;
    logic [15:0] stp;
    logic [15:0] frm;
    stp = (st == 16'd0) ? 16'd1 : st;
    frm = (fr == 16'd0) ? 16'd1 : fr;
    n = 0;
    x = {1'b0, s};
    while (x[16] == 1'b0 && x[15:0] <= e) begin
      sb.push_back({8'd1, 8'd0, x[15:0]});
      sb.push_back({8'd2, 24'd0});
      sb.push_back({8'd4, 8'd0, frm});
      n++;
      x = {1'b0, x[15:0]} + {1'b0, stp};
    end
  endtask

  task automatic pulse_go(
    input logic [15:0] s,
    input logic [15:0] e,
    input logic [15:0] st,
    input logic [15:0] fr
  );
    exp_start = s;
    exp_end = e;
    exp_step = st;
    frames_per_exp = fr;
    sweep_id++;
    @(posedge Clock);
    #1 go = 1'b1;
    @(posedge Clock);
    #1 go = 1'b0;
  endtask

  task automatic wait_idle(input string tag, output int n);
    n = 0;
    @(negedge Clock);
    while (busy && n < 4000) begin
      @(negedge Clock);
      n++;
    end
    check({tag, "_settle"}, 32'(busy), 32'd0);
  endtask

  task automatic run(
    input string       tag,
    input logic [15:0] s,
    input logic [15:0] e,
    input logic [15:0] st,
    input logic [15:0] fr
  );
    int n;
    int w;
    push_sweep(s, e, st, fr, n);
    pulse_go(s, e, st, fr);
    wait_idle(tag, w);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_index"}, 32'(cur_index), 32'(n));
    check({tag, "_drain"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int w;
    Reset = 1'b1;
    go = 1'b0;
    abort = 1'b0;
    exp_start = 16'd0;
    exp_end = 16'd0;
    exp_step = 16'd0;
    frames_per_exp = 16'd0;
    #3;
    check("rst_pulses",
          {29'd0, Config_start, Capture_start, Capture_stop}, 32'd0);
    check("rst_exp", 32'(Config_Exposure), 32'h100);
    check("rst_flags", {29'd0, busy, done, error}, 32'd0);
    check("rst_index", 32'(cur_index), 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    repeat (2) @(negedge Clock);

    run("basic", 16'h0100, 16'h0300, 16'h0100, 16'd2);

    fc_load_val = 32'hFFFF_FFFF;
    fc_load_n++;
    repeat (2) @(negedge Clock);
    run("wrap", 16'h0040, 16'h0040, 16'h0001, 16'd3);
    check("wrap_base", base_seen, 32'hFFFF_FFFF);
    check("wrap_stop", last_stop_fc, 32'h0000_0002);

    stuck = 1'b1;
    sb.push_back({8'd1, 8'd0, 16'h0005});
    pulse_go(16'h0005, 16'h0005, 16'h0001, 16'd1);
    wait_idle("tmo", w);
    check("tmo_error", 32'(error), 32'd1);
    check("tmo_done", 32'(done), 32'd0);
    check("tmo_index", 32'(cur_index), 32'd0);
    check("tmo_time", 32'(w >= 95 && w <= 110), 32'd1);
    check("tmo_drain", 32'(sb.size()), 32'd0);
    stuck = 1'b0;
    repeat (3) @(negedge Clock);

    mask_delta = 1'b1;
    sb.push_back({8'd1, 8'd0, 16'h0010});
    sb.push_back({8'd2, 24'd0});
    sb.push_back({8'd4, 24'd0});
    pulse_go(16'h0010, 16'h0010, 16'h0001, 16'd5);
    w = 0;
    while (!Capture_start && w < 500) begin
      @(negedge Clock);
      w++;
    end
    check("abort_reach", 32'(Capture_start), 32'd1);
    repeat (20) @(negedge Clock);
    @(posedge Clock);
    #1 abort = 1'b1;
    @(posedge Clock);
    #1 abort = 1'b0;
    wait_idle("abort", w);
    check("abort_done", 32'(done), 32'd0);
    check("abort_index", 32'(cur_index), 32'd1);
    check("abort_drain", 32'(sb.size()), 32'd0);
    mask_delta = 1'b0;

    run("zero", 16'h0001, 16'h0003, 16'h0000, 16'd0);
    run("top", 16'hFFF0, 16'hFFFF, 16'h0010, 16'd1);
    run("rev", 16'h0005, 16'h0003, 16'h0001, 16'd1);

    sb.push_back({8'd1, 8'd0, 16'h0180});
    pulse_go(16'h0180, 16'h0300, 16'h0080, 16'd1);
    w = 0;
    while (!Config_start && w < 50) begin
      @(negedge Clock);
      w++;
    end
    repeat (5) @(negedge Clock);
    check("rst_pre_busy", 32'(busy), 32'd1);
    #2 Reset = 1'b1;
    #1;
    check("rst2_pulses",
          {29'd0, Config_start, Capture_start, Capture_stop}, 32'd0);
    check("rst2_exp", 32'(Config_Exposure), 32'h100);
    check("rst2_flags", {29'd0, busy, done, error}, 32'd0);
    check("rst2_index", 32'(cur_index), 32'd0);
    check("rst2_drain", 32'(sb.size()), 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    repeat (12) @(negedge Clock);
    run("after", 16'h0200, 16'h0200, 16'h0001, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
